// File: rtl/core_fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding / hazard controller.
package core_fwd_pkg;

  // Register-index width carried inside the hazard tags.
  localparam int TAG_RD_W  = 5;
  localparam int FWD_SEL_W = 3;

  // Forwarding-mux select encodings.
  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 3'b000;  // register file
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 3'b001;  // MEM-stage ALU result
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = 3'b010;  // WB result
  localparam logic [FWD_SEL_W-1:0] FWD_PWB = 3'b011;  // post-WB held value
  localparam logic [FWD_SEL_W-1:0] FWD_MAC = 3'b100;  // MAC result, MEM producer

  // Destination tag tracked down the pipeline.
  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                we;
    logic                is_load;
    logic                is_mac;
  } hz_tag_t;

  // EX additionally remembers its source operands for forwarding.
  typedef struct packed {
    hz_tag_t             tag;
    logic [TAG_RD_W-1:0] rs1;
    logic [TAG_RD_W-1:0] rs2;
    logic                rs1_used;
    logic                rs2_used;
  } ex_tag_t;

  localparam hz_tag_t HZ_TAG_NONE = '0;
  localparam ex_tag_t EX_TAG_NONE = '0;

  // A tag produces a forwardable value only if it writes a non-zero register.
  function automatic logic tag_live(input hz_tag_t t);
    return t.valid && t.we && (t.rd != '0);
  endfunction

  function automatic logic tag_hits(input hz_tag_t t, input logic [TAG_RD_W-1:0] rs);
    return tag_live(t) && (t.rd == rs);
  endfunction

  // Youngest producer wins: MEM, then WB, then PWB, else register file.
  function automatic logic [FWD_SEL_W-1:0] fwd_select(
    input logic                ex_valid,
    input logic                used,
    input logic [TAG_RD_W-1:0] rs,
    input hz_tag_t             mem,
    input hz_tag_t             wb,
    input hz_tag_t             pwb
  );
    logic [FWD_SEL_W-1:0] sel;
    sel = FWD_RF;
    if (ex_valid && used && (rs != '0)) begin
      if (tag_hits(mem, rs)) begin
        sel = mem.is_mac ? FWD_MAC : FWD_MEM;
      end else if (tag_hits(wb, rs)) begin
        sel = FWD_WB;
      end else if (tag_hits(pwb, rs)) begin
        sel = FWD_PWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mac_busy_counter.sv
// Counts the remaining cycles a MAC instruction keeps EX occupied.
module mac_busy_counter #(
  parameter int MAC_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,   // MAC entering EX: start a fresh count
  input  logic dec_i,    // count down one cycle
  input  logic clr_i,    // abandon the count immediately
  output logic busy_o    // cycles remaining > 0
);

  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  // The MAC's first EX cycle is not counted, so MAC_LAT-1 stall cycles follow.
  localparam logic [CW-1:0] LOAD_VAL = CW'(MAC_LAT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear beats load beats decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation plus load-use and MAC-busy stall control.
// Keeps its own EX/MEM/WB/PWB destination-tag pipeline alongside the datapath.
module fwd_hazard_ctrl
  import core_fwd_pkg::*;
#(
  parameter int REG_AW  = TAG_RD_W,
  parameter int MAC_LAT = 3,
  parameter int SEL_W   = FWD_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_is_mac,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              stall_ex,
  output logic              mac_busy
);

  ex_tag_t ex_q,  ex_d;
  hz_tag_t mem_q, mem_d;
  hz_tag_t wb_q,  wb_d;
  hz_tag_t pwb_q, pwb_d;

  logic mac_cnt_busy;
  logic mac_stall;
  logic load_use_raw;
  logic load_use;
  logic ex_enter;
  logic mac_load;

  // ---------------------------------------------------------------------------
  // Forwarding selects: one identical comparator chain per EX source operand.
  // ---------------------------------------------------------------------------
  logic [1:0][TAG_RD_W-1:0]  ex_rs;
  logic [1:0]                ex_used;
  logic [1:0][FWD_SEL_W-1:0] sel;

  assign ex_rs   = {ex_q.rs2, ex_q.rs1};
  assign ex_used = {ex_q.rs2_used, ex_q.rs1_used};

  for (genvar gi = 0; gi < 2; gi++) begin : g_opsel
    assign sel[gi] = fwd_select(ex_q.tag.valid, ex_used[gi], ex_rs[gi],
                                mem_q, wb_q, pwb_q);
  end

  assign fwd_sel_a = SEL_W'(sel[0]);
  assign fwd_sel_b = SEL_W'(sel[1]);

  // ---------------------------------------------------------------------------
  // Stall / bubble decisions. These depend only on registered tags, the ID
  // decode and flush, never on the forwarding selects.
  // ---------------------------------------------------------------------------

  // A redirect squashes the ID instruction, so it also cancels any MAC hold.
  assign mac_stall = mac_cnt_busy & ~flush;

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    load_use_raw = 1'b0;
    if (id_valid && tag_live(ex_q.tag) && ex_q.tag.is_load) begin
      load_use_raw = (id_rs1_used && (id_rs1 == ex_q.tag.rd)) ||
                     (id_rs2_used && (id_rs2 == ex_q.tag.rd));
    end
  end

  // Flush beats load-use; a MAC hold beats it too and it is re-checked afterwards.
  assign load_use = load_use_raw & ~flush & ~mac_stall;

  assign stall_if_id = load_use | mac_stall;
  assign bubble_ex   = load_use;
  assign stall_ex    = mac_stall;
  assign mac_busy    = mac_stall;

  // The ID instruction moves into EX only when nothing holds or squashes it.
  assign ex_enter = ~mac_stall & id_valid & ~flush & ~load_use;
  assign mac_load = ex_enter & id_is_mac;

  mac_busy_counter #(
    .MAC_LAT (MAC_LAT)
  ) u_mac_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (mac_load),
    .dec_i  (mac_cnt_busy),
    .clr_i  (flush),
    .busy_o (mac_cnt_busy)
  );

  // ---------------------------------------------------------------------------
  // Tag pipeline next state.
  // ---------------------------------------------------------------------------

  // Advance normally; during a MAC hold EX keeps its tag and MEM receives a bubble.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    pwb_d = pwb_q;
    if (mac_stall) begin
      mem_d = HZ_TAG_NONE;
      wb_d  = mem_q;
      pwb_d = wb_q;
    end else begin
      pwb_d = wb_q;
      wb_d  = mem_q;
      mem_d = ex_q.tag;
      if (ex_enter) begin
        ex_d.tag.valid   = 1'b1;
        ex_d.tag.rd      = id_rd;
        ex_d.tag.we      = id_rd_we;
        ex_d.tag.is_load = id_is_load;
        ex_d.tag.is_mac  = id_is_mac;
        ex_d.rs1         = id_rs1;
        ex_d.rs2         = id_rs2;
        ex_d.rs1_used    = id_rs1_used;
        ex_d.rs2_used    = id_rs2_used;
      end else begin
        ex_d = EX_TAG_NONE;
      end
    end
  end

  // Tag registers; reset invalidates every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= EX_TAG_NONE;
      mem_q <= HZ_TAG_NONE;
      wb_q  <= HZ_TAG_NONE;
      pwb_q <= HZ_TAG_NONE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      pwb_q <= pwb_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl (MAC_LAT = 3).
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_mac;
  logic       flush;
  logic [2:0] fwd_sel_a, fwd_sel_b;
  logic       stall_if_id, bubble_ex, stall_ex, mac_busy;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_AW  (5),
    .MAC_LAT (3),
    .SEL_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .id_is_mac   (id_is_mac),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .stall_ex    (stall_ex),
    .mac_busy    (mac_busy)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mac;
  } id_t;

  // {sel_a, sel_b, stall_if_id, bubble_ex, stall_ex, mac_busy}
  typedef struct packed {
    logic [2:0] sa;
    logic [2:0] sb;
    logic       st;
    logic       bb;
    logic       sx;
    logic       bz;
  } exp_t;

  typedef struct {
    string name;
    bit    chk;
    logic  rst_n;
    logic  flush;
    id_t   id;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];

  localparam id_t  ID_NONE = '0;
  localparam exp_t E0      = '0;
  localparam exp_t EBUSY   = '{sa: 3'b000, sb: 3'b000, st: 1'b1, bb: 1'b0, sx: 1'b1, bz: 1'b1};

  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_t t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.u1 = 1'b1; t.u2 = 1'b1; t.we = 1'b1;
    return t;
  endfunction

  function automatic id_t alu_rs2_unused(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_t t = alu(rd, rs1, rs2);
    t.u2 = 1'b0;
    return t;
  endfunction

  function automatic id_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    id_t t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.u1 = 1'b1; t.we = 1'b1; t.ld = 1'b1;
    return t;
  endfunction

  function automatic id_t mac(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_t t = alu(rd, rs1, rs2);
    t.mac = 1'b1;
    return t;
  endfunction

  function automatic exp_t esel(input logic [2:0] sa, input logic [2:0] sb);
    exp_t e = '0;
    e.sa = sa; e.sb = sb;
    return e;
  endfunction

  task automatic add_vec(input string nm, input bit chk, input logic rst, input logic fl,
                         input id_t id, input exp_t e);
    vec_t v;
    v.name = nm; v.chk = chk; v.rst_n = rst; v.flush = fl; v.id = id; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic set_id(input id_t t);
    id_valid    = t.valid;
    id_rs1      = t.rs1;
    id_rs2      = t.rs2;
    id_rs1_used = t.u1;
    id_rs2_used = t.u2;
    id_rd       = t.rd;
    id_rd_we    = t.we;
    id_is_load  = t.ld;
    id_is_mac   = t.mac;
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end else begin
      $display("ok   %s: %0h", nm, got);
    end
  endtask

  task automatic check_outs(input int idx, input string nm, input exp_t e);
    exp_t got;
    got = '{sa: fwd_sel_a, sb: fwd_sel_b, st: stall_if_id, bb: bubble_ex, sx: stall_ex, bz: mac_busy};
    ncmp++;
    if (got !== e) begin
      nfail++;
      $display("FAIL [%0d] %s: got sel_a=%b sel_b=%b stall_if_id=%b bubble_ex=%b stall_ex=%b mac_busy=%b, want sel_a=%b sel_b=%b stall_if_id=%b bubble_ex=%b stall_ex=%b mac_busy=%b",
               idx, nm, got.sa, got.sb, got.st, got.bb, got.sx, got.bz,
               e.sa, e.sb, e.st, e.bb, e.sx, e.bz);
    end else begin
      $display("ok   [%0d] %s: sel_a=%b sel_b=%b stall_if_id=%b bubble_ex=%b stall_ex=%b mac_busy=%b",
               idx, nm, got.sa, got.sb, got.st, got.bb, got.sx, got.bz);
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cycles;
    exp_t ld_stall;
    ld_stall = '{sa: 3'b000, sb: 3'b000, st: 1'b1, bb: 1'b1, sx: 1'b0, bz: 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    set_id(ID_NONE);

    // ---- reset ----
    add_vec("reset_apply",   0, 0, 0, ID_NONE,       E0);
    add_vec("reset_state",   1, 0, 0, ID_NONE,       E0);
    // ---- back-to-back ALU chain ----
    add_vec("alu_x5_issue",  1, 1, 0, alu(5, 1, 2),  E0);
    add_vec("alu_x6_issue",  1, 1, 0, alu(6, 5, 5),  E0);
    add_vec("x6_src_mem",    1, 1, 0, alu(7, 5, 6),  esel(3'b001, 3'b001));
    add_vec("x7_src_wb_mem", 1, 1, 0, ID_NONE,       esel(3'b010, 3'b001));
    add_vec("x9_issue",      1, 1, 0, alu(9, 6, 7),  E0);
    add_vec("x9_src_pwb_wb", 1, 1, 0, ID_NONE,       esel(3'b011, 3'b010));
    add_vec("drain0",        1, 1, 0, ID_NONE,       E0);
    add_vec("drain1",        1, 1, 0, ID_NONE,       E0);
    add_vec("drain2",        1, 1, 0, ID_NONE,       E0);
    // ---- load-use ----
    add_vec("lw_x3_issue",   1, 1, 0, lw(3, 1),      E0);
    add_vec("load_use_stall",1, 1, 0, alu(4, 3, 3),  ld_stall);
    add_vec("load_use_held", 1, 1, 0, alu(4, 3, 3),  E0);
    add_vec("load_use_wb",   1, 1, 0, ID_NONE,       esel(3'b010, 3'b010));
    add_vec("drain3",        1, 1, 0, ID_NONE,       E0);
    add_vec("drain4",        1, 1, 0, ID_NONE,       E0);
    add_vec("drain5",        1, 1, 0, ID_NONE,       E0);
    // ---- MAC then dependent add ----
    add_vec("mac_x8_issue",  1, 1, 0, mac(8, 1, 2),  E0);
    add_vec("mac_busy_1",    1, 1, 0, alu(10, 8, 8), EBUSY);
    add_vec("mac_busy_2",    1, 1, 0, alu(10, 8, 8), EBUSY);
    add_vec("mac_release",   1, 1, 0, alu(10, 8, 8), E0);
    add_vec("mac_fwd",       1, 1, 0, ID_NONE,       esel(3'b100, 3'b100));
    add_vec("drain6",        1, 1, 0, ID_NONE,       E0);
    add_vec("drain7",        1, 1, 0, ID_NONE,       E0);
    add_vec("drain8",        1, 1, 0, ID_NONE,       E0);
    // ---- x0 and unused sources ----
    add_vec("add_x0_issue",  1, 1, 0, alu(0, 1, 2),  E0);
    add_vec("read_x0_issue", 1, 1, 0, alu(11, 0, 0), E0);
    add_vec("read_x0_ex",    1, 1, 0, alu_rs2_unused(12, 13, 11), E0);
    add_vec("rs2_unused_ex", 1, 1, 0, ID_NONE,       E0);
    add_vec("lw_x14_issue",  1, 1, 0, lw(14, 1),     E0);
    add_vec("lw_unused_src", 1, 1, 0, alu_rs2_unused(15, 1, 14), E0);
    add_vec("unused_ex",     1, 1, 0, ID_NONE,       E0);
    // ---- flush coincident with load-use ----
    add_vec("lw_x3_again",   1, 1, 0, lw(3, 1),      E0);
    add_vec("flush_loaduse", 1, 1, 1, alu(4, 3, 3),  E0);
    add_vec("flush_ex_inv",  1, 1, 0, ID_NONE,       E0);
    // ---- reset during MAC stall, then full restart ----
    add_vec("mac_pre_rst",   1, 1, 0, mac(8, 1, 2),  E0);
    add_vec("mac_rst_busy",  1, 1, 0, ID_NONE,       EBUSY);
    add_vec("mac_rst_edge",  1, 0, 0, ID_NONE,       EBUSY);
    add_vec("post_rst_mac",  1, 1, 0, mac(8, 1, 2),  E0);
    add_vec("restart_busy1", 1, 1, 0, ID_NONE,       EBUSY);
    add_vec("restart_busy2", 1, 1, 0, ID_NONE,       EBUSY);
    add_vec("restart_done",  1, 1, 0, ID_NONE,       E0);
    add_vec("restart_drain", 1, 1, 0, ID_NONE,       E0);

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    foreach (vecs[k]) begin
      @(negedge clk);
      rst_n = vecs[k].rst_n;
      flush = vecs[k].flush;
      set_id(vecs[k].id);
      #1;
      if (vecs[k].chk) check_outs(k, vecs[k].name, vecs[k].e);
    end

    // ---- MAC occupancy measured with a bounded wait ----
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0;
    set_id(mac(8, 1, 2));
    @(negedge clk);
    set_id(ID_NONE);
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!mac_busy) break;
      busy_cycles++;
      @(negedge clk);
    end
    check_val("mac_busy_cycles", busy_cycles, 2);

    // ---- flush during a MAC hold releases it and clears the count ----
    @(negedge clk);
    set_id(mac(8, 1, 2));
    @(negedge clk);
    set_id(ID_NONE);
    #1;
    check_val("flush_pre_busy", {stall_if_id, stall_ex, mac_busy}, 3'b111);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check_val("flush_in_busy", {stall_if_id, bubble_ex, stall_ex, mac_busy}, 4'b0000);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_val("flush_cleared", {stall_if_id, stall_ex, mac_busy}, 3'b000);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
